// File: rtl/framer_tx.sv
// framer_tx: serial frame transmitter for the 1001-sync link.
//
// Each frame is the 4-bit SYNC word followed by NIBBLES payload nibbles.
// Bits leave MSB first, one per clock. Payload nibbles arrive over a
// valid/ready handshake. A nibble accepted in cycle t is driven on the line
// in cycles t+1..t+4. A missing nibble is sent as 0000 and sets a sticky
// underrun flag.
//
// Ports:
//   clk         rising-edge clock, one serial bit per cycle
//   reset       synchronous, active-high reset
//   en          transmit enable, only acted on at a frame boundary
//   data_in     payload nibble
//   data_valid  data_in holds a valid nibble
//   data_ready  nibble is taken this cycle if data_valid=1 (registered)
//   out         serial line (registered)
//   frame       high during the first sync bit of every frame (registered)
//   count       frames fully transmitted, wraps 255->0
//   flag        sticky underrun indicator
module framer_tx #(
    parameter logic [3:0]  SYNC    = 4'b1001,
    parameter int unsigned NIBBLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [3:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       out,
    output logic       frame,
    output logic [7:0] count,
    output logic       flag
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA
    } state_t;

    localparam logic [5:0] LAST_NIB = 6'(NIBBLES - 1);

    state_t     state;
    logic [1:0] bit_idx;    // bit currently on the line, 3..0
    logic [5:0] nib_idx;    // payload nibble currently on the line
    logic [3:0] shift_reg;  // remaining bits of the current nibble, MSB next
    logic [3:0] fetched;    // nibble loaded at the end of a ready cycle

    // A missing nibble is replaced by zeros.
    always_comb begin
        fetched = data_valid ? data_in : '0;
    end

    // The registered outputs always describe the bit currently on the line.
    // Each edge therefore computes the next bit, so no input reaches an
    // output without passing through a flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            bit_idx    <= '0;
            nib_idx    <= '0;
            shift_reg  <= '0;
            out        <= 1'b0;
            frame      <= 1'b0;
            data_ready <= 1'b0;
            count      <= '0;
            flag       <= 1'b0;
        end else begin
            frame      <= 1'b0;
            data_ready <= 1'b0;

            // A ready cycle without valid data is an underrun.
            if (data_ready && !data_valid) begin
                flag <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    out <= 1'b0;
                    if (en) begin
                        state   <= ST_SYNC;
                        bit_idx <= 2'd3;
                        nib_idx <= '0;
                        out     <= SYNC[3];
                        frame   <= 1'b1;
                    end
                end

                ST_SYNC: begin
                    if (bit_idx != 2'd0) begin
                        bit_idx    <= bit_idx - 2'd1;
                        out        <= SYNC[bit_idx - 2'd1];
                        // The last sync bit doubles as the fetch cycle for nibble 0.
                        data_ready <= (bit_idx == 2'd1);
                    end else begin
                        state     <= ST_DATA;
                        bit_idx   <= 2'd3;
                        nib_idx   <= '0;
                        out       <= fetched[3];
                        shift_reg <= {fetched[2:0], 1'b0};
                    end
                end

                ST_DATA: begin
                    if (bit_idx != 2'd0) begin
                        bit_idx    <= bit_idx - 2'd1;
                        out        <= shift_reg[3];
                        shift_reg  <= {shift_reg[2:0], 1'b0};
                        // Bit 0 of every nibble except the last fetches the next one.
                        data_ready <= (bit_idx == 2'd1) && (nib_idx != LAST_NIB);
                    end else if (nib_idx != LAST_NIB) begin
                        nib_idx   <= nib_idx + 6'd1;
                        bit_idx   <= 2'd3;
                        out       <= fetched[3];
                        shift_reg <= {fetched[2:0], 1'b0};
                    end else begin
                        // Frame complete. en decides between back-to-back and idle.
                        count   <= count + 8'd1;
                        nib_idx <= '0;
                        if (en) begin
                            state   <= ST_SYNC;
                            bit_idx <= 2'd3;
                            out     <= SYNC[3];
                            frame   <= 1'b1;
                        end else begin
                            state   <= ST_IDLE;
                            bit_idx <= '0;
                            out     <= 1'b0;
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    out   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_framer_tx.sv
// tb_framer_tx: directed and randomized bench for framer_tx.
//
// The reference model tracks only the position inside the frame (0..L-1, or
// -1 when idle). The expected line bit, frame strobe and ready strobe are
// derived from that position with plain arithmetic. Nibbles taken at ready
// cycles are stored per slot and replayed when their slot comes up.
module tb_framer_tx;

    localparam int         NIB    = 8;
    localparam int         L      = 4 * (NIB + 1);
    localparam logic [3:0] SYNC_W = 4'b1001;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [3:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic       out;
    logic       frame;
    logic [7:0] count;
    logic       flag;

    always #5 clk = ~clk;

    framer_tx #(
        .SYNC    (SYNC_W),
        .NIBBLES (NIB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .out        (out),
        .frame      (frame),
        .count      (count),
        .flag       (flag)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int         pos_m   = -1;
    int         count_m = 0;
    logic       flag_m  = 1'b0;
    logic [3:0] nib_m [NIB];

    // Stimulus control
    int           src_mode;    // 0: counter 1,2,3..  1: constant 1001  2: random
    int           valid_mode;  // 0: always valid  1: drop nibble 2  2: random
    int           src_cnt;
    logic [127:0] cap;

    function automatic logic m_ready();
        return (pos_m >= 0) && (pos_m % 4 == 3) && (pos_m < L - 1);
    endfunction

    function automatic logic [11:0] m_outputs();
        logic o;
        if (pos_m < 0)      o = 1'b0;
        else if (pos_m < 4) o = SYNC_W[3 - pos_m];
        else                o = nib_m[(pos_m - 4) / 4][3 - (pos_m % 4)];
        return {o, (pos_m == 0), m_ready(), 8'(count_m), flag_m};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, compare at negedge.
    task automatic step();
        logic [3:0] nib;
        case (src_mode)
            0:       data_in = 4'(src_cnt + 1);
            1:       data_in = 4'b1001;
            default: data_in = 4'($urandom_range(0, 15));
        endcase
        case (valid_mode)
            0:       data_valid = 1'b1;
            1:       data_valid = !(m_ready() && ((pos_m - 3) / 4 == 2));
            default: data_valid = ($urandom_range(0, 9) != 0);
        endcase
        @(posedge clk);
        if (reset) begin
            pos_m   = -1;
            count_m = 0;
            flag_m  = 1'b0;
        end else if (pos_m < 0) begin
            if (en) pos_m = 0;
        end else begin
            if (m_ready()) begin
                nib = data_valid ? data_in : 4'b0000;
                if (!data_valid)        flag_m = 1'b1;
                else if (src_mode == 0) src_cnt++;
                nib_m[(pos_m - 3) / 4] = nib;
            end
            if (pos_m == L - 1) begin
                count_m = (count_m + 1) % 256;
                pos_m   = en ? 0 : -1;
            end else begin
                pos_m++;
            end
        end
        @(negedge clk);
        chk("cycle", 128'({out, frame, data_ready, count, flag}), 128'(m_outputs()));
        cap = {cap[126:0], out};
    endtask

    initial begin
        int   c0;
        int   len;
        logic rd_seen;
        logic seen255;

        reset = 1'b1; en = 1'b0; data_valid = 1'b0; data_in = 4'd0;
        src_mode = 2; valid_mode = 0; src_cnt = 0; cap = '0;

        // Reset, then a long idle stretch
        step(); step();
        reset = 1'b0;
        chk("reset_state", 128'({out, frame, data_ready, count, flag}), 128'(12'h000));
        repeat (50) step();
        chk("idle_hold", 128'({out, frame, data_ready, count, flag}), 128'(12'h000));

        // Single frame carrying nibbles 1..8
        src_mode = 0; src_cnt = 0; valid_mode = 0;
        en = 1'b1; cap = '0;
        step();
        en = 1'b0;
        repeat (L - 1) step();
        chk("single_bits", 128'(cap[35:0]), 128'(36'h9_1234_5678));
        step();
        chk("single_count", 128'(count), 128'(8'd1));
        chk("single_flag", 128'(flag), 128'(1'b0));
        repeat (5) step();
        chk("single_idle_out", 128'({out, data_ready}), 128'(2'b00));

        // Three back-to-back frames of constant 1001 data
        src_mode = 1; c0 = count_m; cap = '0;
        en = 1'b1;
        repeat (2 * L + 1) step();
        en = 1'b0;
        repeat (L - 1) step();
        chk("continuous_bits", 128'(cap[107:0]), 128'({27{4'h9}}));
        step();
        chk("continuous_count", 128'(count), 128'(8'(c0 + 3)));

        // Underrun on nibble 2
        src_mode = 2; valid_mode = 1;
        chk("flag_before_underrun", 128'(flag), 128'(1'b0));
        en = 1'b1; cap = '0;
        step();
        en = 1'b0;
        repeat (L - 1) step();
        chk("underrun_nib2", 128'(cap[23:20]), 128'(4'h0));
        step();
        chk("underrun_flag_sticky", 128'(flag), 128'(1'b1));
        valid_mode = 0;

        // en dropped at bit 10: the frame still runs to completion
        c0 = count_m; len = 0;
        en = 1'b1;
        step();
        if (pos_m >= 0) len++;
        for (int i = 0; i < 20 && pos_m < 10; i++) begin
            step();
            if (pos_m >= 0) len++;
        end
        en = 1'b0;
        for (int i = 0; i < 2 * L && pos_m >= 0; i++) begin
            step();
            if (pos_m >= 0) len++;
        end
        chk("endrop_len", 128'(len), 128'(L));
        chk("endrop_count", 128'(count), 128'(8'(c0 + 1)));
        repeat (3) step();
        chk("endrop_idle", 128'({out, frame, data_ready}), 128'(3'b000));

        // Reset at bit 20 of a new frame
        en = 1'b1;
        step();
        for (int i = 0; i < 40 && pos_m < 20; i++) step();
        reset = 1'b1; en = 1'b0;
        step();
        reset = 1'b0;
        chk("midreset_outputs", 128'({out, frame, data_ready, count, flag}), 128'(12'h000));
        rd_seen = 1'b0;
        repeat (40) begin
            step();
            rd_seen = rd_seen | data_ready;
        end
        chk("midreset_no_ready", 128'(rd_seen), 128'(1'b0));

        // Random en and randomly missing data
        src_mode = 2; valid_mode = 2;
        repeat (400) begin
            en = ($urandom_range(0, 3) != 0);
            step();
        end
        en = 1'b0;
        for (int i = 0; i < 2 * L && pos_m >= 0; i++) step();
        valid_mode = 0;

        // Counter wrap over 256 back-to-back frames
        reset = 1'b1;
        step();
        reset = 1'b0;
        seen255 = 1'b0;
        en = 1'b1;
        for (int i = 0; i < 255 * L + 1; i++) begin
            step();
            if (!seen255 && count_m == 255) begin
                seen255 = 1'b1;
                chk("wrap_255", 128'(count), 128'(8'd255));
            end
        end
        en = 1'b0;
        repeat (L) step();
        chk("wrap_0", 128'(count), 128'(8'd0));
        chk("wrap_idle", 128'({out, data_ready}), 128'(2'b00));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/framer_tx.md
# framer_tx

Serial frame transmitter for the 1001-sync link; it is the transmit end of the path whose receiver hunts for the 1001 pattern. It accepts payload nibbles over a valid/ready handshake and emits one bit per clock, MSB first. Each frame is the 4-bit sync word followed by a fixed number of payload nibbles. A frame counter and a sticky underrun flag support link bring-up and debug.

## Interface
- SYNC, 4'b1001, sync word sent at the start of every frame, bit 3 first
- NIBBLES, 8, payload nibbles per frame (1..63)

- clk  input  1  rising-edge clock; one serial bit per cycle
- reset  input  1  synchronous, active-high reset
- en  input  1  transmit enable; sampled at the frame boundary
- data_in  input  4  payload nibble
- data_valid  input  1  data_in holds a valid nibble
- data_ready  output  1  nibble accepted this cycle if data_valid=1
- out  output  1  serial line, registered
- frame  output  1  high during the first sync bit of every frame
- count  output  8  frames fully transmitted, wraps 255->0
- flag  output  1  sticky underrun indicator

## Operation
- States are IDLE, SYNC and DATA. Internal bit index runs 3..0; the nibble index runs 0..NIBBLES-1.
- Reset values: state IDLE, out=0, frame=0, data_ready=0, count=0, flag=0, and both indices cleared.
- IDLE:
  - out=0.
  - If en=1 at a rising edge, the next cycle enters SYNC with bit index 3.
- SYNC:
  - out=SYNC[i] for i=3,2,1,0 over four cycles.
  - frame=1 only while i=3.
  - After i=0, go to DATA with nibble 0, bit 3.
- DATA:
  - out=shift_reg[3] each cycle, and shift_reg shifts left.
  - After bit 0 of nibble NIBBLES-1 the frame is complete and count increments by 1.
  - If en=1 in that last-bit cycle, go to SYNC (back-to-back frames, no gap). Otherwise go to IDLE.
- Nibble fetch:
  - data_ready=1 for exactly one cycle before each nibble: the last SYNC bit for nibble 0, and bit 0 of the previous nibble for the others.
  - data_valid=1 in that cycle: data_in loads into shift_reg.
  - data_valid=0 in that cycle: shift_reg loads 4'b0000 and flag sets. flag stays set until reset.
  - data_ready is 0 in every other cycle. data_valid outside a ready cycle is ignored and nothing is consumed.
- en deasserted mid-frame: the current frame completes fully, then the block enters IDLE. en has no effect before the frame boundary.
- reset mid-frame: the next cycle shows reset values, the partial frame is abandoned and count is not incremented.
- Simultaneous frame completion and reset: reset wins and count=0.

## Timing
- en=1 sampled at edge k:
  - out=SYNC[3] and frame=1 during cycle k+1.
  - SYNC[0] during k+4, together with data_ready=1.
  - Nibble 0 bits 3..0 during k+5..k+8.
- Frame length L = 4*(NIBBLES+1) cycles, which is 36 at the default.
- Back-to-back frames: the next frame=1 comes exactly L cycles after the previous one.
- count updates at the edge ending the last payload bit and is visible in the following cycle.
- flag is set at the edge ending the failed ready cycle.
- Input-to-line latency: a nibble accepted in cycle t appears MSB-first on out in cycles t+1..t+4.
- No combinational path from any input to any output.

## Test plan
- Reset then idle: reset=1 for 2 cycles with en=0 -> out=0, frame=0, data_ready=0, count=0, flag=0 held for 50 cycles.
- Single frame:
  - Stimulus: en=1 for one cycle, NIBBLES=8, source always valid with nibbles 1,2,...,8.
  - Response: out = 1001 0001 0010 ... 1000 (36 bits), frame high on the first bit only, count=1, flag=0, then out=0 in IDLE.
- Continuous transmission:
  - Stimulus: en held 1 for 3 frames with data_in=4'b1001 always valid.
  - Response: 108 bits of repeating 1001, frame pulses 36 cycles apart, count=3 after the third frame.
- Underrun: data_valid=0 at the nibble-2 ready cycle -> nibble 2 transmitted as 0000, flag=1 from that edge and still 1 after the frame completes. The other nibbles are unaffected.
- en drop and reset mid-frame:
  - Stimulus: drop en at bit 10 of a frame.
  - Response: the frame completes all 36 bits, then IDLE.
  - Stimulus: then assert reset at bit 20 of a new frame.
  - Response: the next cycle has out=0, count=0, flag=0, and no further data_ready until en is sampled again.
- Wrap: 256 back-to-back frames -> count reads 255 after frame 255 and 0 after frame 256. The serial pattern is unchanged.
